mips_io_port: RTL and testbench
===============================

# mips_io_port

Memory-mapped I/O port unit on the data side of the MIPS single-cycle processor. Sits beside the data memory on the same Address/WriteData/MemWrite/MemRead bus driven by the ALU result and register file. Registers the 32-bit `PortOut`, synchronizes and optionally debounces the 8-bit `PortIn`, and exposes a read-to-clear change flag. The processor's write-back path selects `ReadData` from this block instead of data memory when `IOSelect` is high.

## Interface
- `DATA_WIDTH`, 32, bus and `PortOut` width
- `IN_WIDTH`, 8, `PortIn` width
- `PORT_OUT_ADDR`, 32'h1001_0024, `PortOut` register address
- `PORT_IN_ADDR`, 32'h1001_0028, synchronized input register address (read-only)
- `STATUS_ADDR`, 32'h1001_002C, status register address
- `DEBOUNCE_CYCLES`, 16, stable-sample count required to accept a new input (used only with debounce compiled in; legal range ≥1)

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge
- `reset`  in  1  synchronous, active-low reset
- `Address`  in  32  byte address from the ALU result
- `WriteData`  in  32  store data (register file ReadData2)
- `MemWrite`  in  1  store strobe
- `MemRead`  in  1  load strobe
- `PortIn`  in  8  asynchronous external input
- `ReadData`  out  32  load data, combinational
- `IOSelect`  out  1  Address hits one of the three I/O registers, combinational
- `PortOut`  out  32  output port register
- `InChanged`  out  1  change flag (mirror of STATUS bit 0)

## Operation
- Decode compares `Address[31:2]` only; byte offset ignored. `IOSelect` = hit on any of the three addresses, independent of `MemRead`/`MemWrite`.
- PORT_OUT: on an edge with `MemWrite` and a PORT_OUT hit, `PortOut <= WriteData`. Otherwise it holds.
- PORT_IN: two-flop synchronizer `sync1 <= PortIn`, `sync2 <= sync1`, feeding the accepted value `in_stable`. Stores to PORT_IN are ignored.
- STATUS:
  - Bit0 = `changed`.
  - Bit1 = `pending` (`sync2 != in_stable`).
  - Bits 31:2 read 0.
  - A store with `WriteData[0]=1` clears `changed` (W1C).
- `changed` is set on any edge where `in_stable` takes a new, different value.
- `changed` is cleared on an edge with `MemRead` and a STATUS hit, or on a W1C store.
- If set and clear occur on the same edge, set wins.
- ReadData, when `MemRead` is asserted:
  - PORT_IN hit: `{24'b0, in_stable}`
  - PORT_OUT hit: `PortOut`
  - STATUS hit: status word
  - any other case (no hit, or `MemRead` low): 0
- `MemRead` and `MemWrite` asserted together on the same address: the write takes effect at the edge; `ReadData` shows the pre-edge value.

## Timing
- Reset (`reset`=0 at an edge) clears `sync1`, `sync2`, `in_stable`, debounce counter, `changed` and `PortOut` to 0. Reset overrides any concurrent access.
- Reset mid-debounce discards the partial count.
- A nonzero `PortIn` after reset is treated as a change and sets `changed`.
- `ReadData` and `IOSelect` have zero latency (combinational), matching single-cycle load timing.
- `PortOut` is visible one edge after the store.
- Without debounce: `in_stable <= sync2` every edge. If `PortIn` changes and is first sampled at edge 0, `in_stable` and `changed` update at edge 2.
- With debounce:
  - The counter (width clog2(`DEBOUNCE_CYCLES`)+1) increments on each edge where `sync2 != in_stable`.
  - It resets to 0 on any edge where they are equal, or where `sync2` differs from its previous value.
  - When the counter equals `DEBOUNCE_CYCLES-1` and the mismatch persists, `in_stable <= sync2`, the counter resets to 0 and `changed` sets.
  - Accept edge = `DEBOUNCE_CYCLES+1` after first sampling (edge 17 by default).
  - Pulses shorter than `DEBOUNCE_CYCLES` cycles at `sync2` are rejected.
  - `DEBOUNCE_CYCLES=1` gives the same latency as no debounce.

## Configuration
- `MIPS_IO_DEBOUNCE_EN` defined: debounce counter is present and `DEBOUNCE_CYCLES` is honoured.
- Not defined: no counter logic; `in_stable` follows `sync2` with one register stage, and `DEBOUNCE_CYCLES` is ignored. STATUS bit1 still reflects `sync2 != in_stable`.

## Test plan
- Reset held 3 cycles then released, `PortIn`=0 -> `PortOut`=0, `InChanged`=0; load from 0x1001002C returns 0.
- Store 0xDEADBEEF to 0x10010024, then load 0x10010024 -> `PortOut`=0xDEADBEEF after one edge; `ReadData`=0xDEADBEEF, `IOSelect`=1. Load 0x10010000 -> `IOSelect`=0, `ReadData`=0.
- `PortIn` 0x00->0xA5 with debounce off -> `in_stable`/`InChanged` update at edge 2; load 0x10010028 returns 0x000000A5. Load 0x1001002C returns 0x1, then `InChanged`=0.
- With debounce on (`DEBOUNCE_CYCLES`=16): a 10-cycle pulse of 0x01 -> no `in_stable` change and `InChanged` stays 0. Held 0x3C -> accepted at edge 17, STATUS reads 0x1.
- Status read coincident with a new accept -> `InChanged` remains 1. A store of 0x1 to 0x1001002C on the next cycle clears it.
- `reset` asserted mid-debounce (count 8) -> counter, `in_stable` and `PortOut` return to 0. A still-held input is re-accepted 17 edges after release.

Source files
------------

// File: rtl/mips_io_port_if.sv
// mips_io_port_if -- data-side bus between the single-cycle MIPS datapath and
// the memory-mapped I/O port unit.
//   Address   : byte address from the ALU result (32 bits)
//   WriteData : store data (register file ReadData2)
//   MemWrite  : store strobe
//   MemRead   : load strobe
//   ReadData  : load data returned by the I/O unit (combinational)
//   IOSelect  : address hits an I/O register (combinational)
// master = processor side, slave = I/O port unit.
interface mips_io_port_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic [31:0]           Address;
  logic [DATA_WIDTH-1:0] WriteData;
  logic                  MemWrite;
  logic                  MemRead;
  logic [DATA_WIDTH-1:0] ReadData;
  logic                  IOSelect;

  modport master (
    output Address, WriteData, MemWrite, MemRead,
    input  ReadData, IOSelect
  );

  modport slave (
    input  Address, WriteData, MemWrite, MemRead,
    output ReadData, IOSelect
  );
endinterface

// File: rtl/mips_io_port.sv
// mips_io_port -- memory-mapped I/O port unit beside the data memory.
// Registers a 32-bit output port, synchronizes (and optionally debounces)
// an 8-bit input port, and exposes a read-to-clear / W1C change flag.
//   clk       : system clock, rising edge
//   reset     : synchronous, active-low
//   bus       : mips_io_port_if.slave (Address/WriteData/MemWrite/MemRead in,
//               ReadData/IOSelect out, both combinational)
//   PortIn    : asynchronous external input
//   PortOut   : output port register
//   InChanged : change flag (STATUS bit 0)
// Optional feature: define MIPS_IO_DEBOUNCE_EN to include the debounce
// counter; otherwise in_stable follows the synchronizer output directly.
module mips_io_port #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned IN_WIDTH        = 8,
  parameter logic [31:0] PORT_OUT_ADDR   = 32'h1001_0024,
  parameter logic [31:0] PORT_IN_ADDR    = 32'h1001_0028,
  parameter logic [31:0] STATUS_ADDR     = 32'h1001_002C,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  mips_io_port_if.slave         bus,
  input  logic [IN_WIDTH-1:0]   PortIn,
  output logic [DATA_WIDTH-1:0] PortOut,
  output logic                  InChanged
);

  logic                hit_out;
  logic                hit_in;
  logic                hit_status;
  logic [IN_WIDTH-1:0] sync1;
  logic [IN_WIDTH-1:0] sync2;
  logic [IN_WIDTH-1:0] in_stable;
  logic                changed;
  logic                pending;
  logic                accept;
  logic                clear_changed;
  logic                unused_addr_bits;

  // Word-aligned decode: byte offset is ignored.
  assign hit_out    = (bus.Address[31:2] == PORT_OUT_ADDR[31:2]);
  assign hit_in     = (bus.Address[31:2] == PORT_IN_ADDR[31:2]);
  assign hit_status = (bus.Address[31:2] == STATUS_ADDR[31:2]);
  assign unused_addr_bits = ^bus.Address[1:0];

  assign bus.IOSelect = hit_out | hit_in | hit_status;
  assign pending      = (sync2 != in_stable);
  assign InChanged    = changed;

  // Status reads clear the flag, as do stores with bit 0 set.
  assign clear_changed = hit_status &
                         (bus.MemRead | (bus.MemWrite & bus.WriteData[0]));

  always_comb begin
    bus.ReadData = '0;
    if (bus.MemRead) begin
      if (hit_in)
        bus.ReadData = DATA_WIDTH'(in_stable);
      else if (hit_out)
        bus.ReadData = PortOut;
      else if (hit_status)
        bus.ReadData = DATA_WIDTH'({pending, changed});
    end
  end

`ifdef MIPS_IO_DEBOUNCE_EN
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;

  logic [CNT_W-1:0] db_count;

  assign accept = pending && (db_count == CNT_W'(DEBOUNCE_CYCLES - 1));

  // sync1 != sync2 means sync2 is about to take a new value, so the run of
  // identical samples ends here; a completing run still accepts first.
  always_ff @(posedge clk) begin
    if (!reset)
      db_count <= '0;
    else if (!pending || accept)
      db_count <= '0;
    else if (sync1 != sync2)
      db_count <= '0;
    else
      db_count <= db_count + CNT_W'(1);
  end
`else
  assign accept = pending;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1     <= '0;
      sync2     <= '0;
      in_stable <= '0;
      changed   <= 1'b0;
      PortOut   <= '0;
    end else begin
      sync1 <= PortIn;
      sync2 <= sync1;
      if (accept)
        in_stable <= sync2;
      // A new accept beats a same-edge clear.
      if (accept)
        changed <= 1'b1;
      else if (clear_changed)
        changed <= 1'b0;
      if (bus.MemWrite && hit_out)
        PortOut <= bus.WriteData;
    end
  end

endmodule

// File: tb/tb_mips_io_port.sv
// tb_mips_io_port -- self-checking bench for mips_io_port.
// A behavioural model tracks the input sample history, the accepted value,
// the change flag and the output register; directed steps follow the test
// plan and are followed by a randomized phase.
module tb_mips_io_port;

  localparam int unsigned D = 16;
`ifdef MIPS_IO_DEBOUNCE_EN
  localparam int unsigned D_EFF = D;
  localparam int unsigned LAT   = D + 1;
`else
  localparam int unsigned D_EFF = 1;
  localparam int unsigned LAT   = 2;
`endif

  localparam logic [31:0] A_OUT = 32'h1001_0024;
  localparam logic [31:0] A_IN  = 32'h1001_0028;
  localparam logic [31:0] A_ST  = 32'h1001_002C;
  localparam logic [31:0] A_MEM = 32'h1001_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  PortIn;
  logic [31:0] PortOut;
  logic        InChanged;

  int checks = 0;
  int errors = 0;

  mips_io_port_if #(.DATA_WIDTH(32)) bus ();

  mips_io_port #(
    .DATA_WIDTH     (32),
    .IN_WIDTH       (8),
    .PORT_OUT_ADDR  (A_OUT),
    .PORT_IN_ADDR   (A_IN),
    .STATUS_ADDR    (A_ST),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .PortIn   (PortIn),
    .PortOut  (PortOut),
    .InChanged(InChanged)
  );

  always #5 clk = ~clk;

  // Reference model state.
  logic [7:0]  m_pipe[$];   // samples not yet visible to the accept logic; [0] is next
  logic [7:0]  m_stable;
  logic [7:0]  m_last;
  int unsigned m_run;       // consecutive edges that have seen m_last
  logic        m_changed;
  logic [31:0] m_out;

  function automatic logic [31:0] exp_rd();
    logic [29:0] w;
    w = bus.Address[31:2];
    if (!bus.MemRead) return 32'h0;
    if (w == A_IN[31:2])  return {24'h0, m_stable};
    if (w == A_OUT[31:2]) return m_out;
    if (w == A_ST[31:2])  return {30'h0, (m_pipe[0] != m_stable), m_changed};
    return 32'h0;
  endfunction

  function automatic logic exp_iosel();
    logic [29:0] w;
    w = bus.Address[31:2];
    return (w == A_IN[31:2]) || (w == A_OUT[31:2]) || (w == A_ST[31:2]);
  endfunction

  task automatic model_edge();
    logic [7:0]  s;
    logic        set_c;
    logic        clr_c;
    logic [29:0] w;
    if (!reset) begin
      m_pipe    = {8'h00, 8'h00};
      m_stable  = 8'h00;
      m_last    = 8'h00;
      m_run     = 0;
      m_changed = 1'b0;
      m_out     = 32'h0;
      return;
    end
    s = m_pipe[0];
    if (s == m_last) m_run++;
    else begin
      m_last = s;
      m_run  = 1;
    end
    set_c = 1'b0;
    if (s != m_stable && m_run >= D_EFF) begin
      m_stable = s;
      set_c    = 1'b1;
    end
    w = bus.Address[31:2];
    clr_c = (w == A_ST[31:2]) && (bus.MemRead || (bus.MemWrite && bus.WriteData[0]));
    if (set_c) m_changed = 1'b1;
    else if (clr_c) m_changed = 1'b0;
    if (bus.MemWrite && w == A_OUT[31:2]) m_out = bus.WriteData;
    void'(m_pipe.pop_front());
    m_pipe.push_back(PortIn);
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
      else begin
        errors++;
        $error("FAIL %s observed %h expected %h", tag, got, exp);
      end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".rd"},    bus.ReadData,       exp_rd());
    chk({tag, ".iosel"}, {31'h0, bus.IOSelect}, {31'h0, exp_iosel()});
    chk({tag, ".pout"},  PortOut,            m_out);
    chk({tag, ".chg"},   {31'h0, InChanged}, {31'h0, m_changed});
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] d,
                       input logic w, input logic r);
    bus.Address   = a;
    bus.WriteData = d;
    bus.MemWrite  = w;
    bus.MemRead   = r;
    #1;
  endtask

  task automatic tick(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    m_pipe    = {8'h00, 8'h00};
    m_stable  = 8'h00;
    m_last    = 8'h00;
    m_run     = 0;
    m_changed = 1'b0;
    m_out     = 32'h0;

    // Reset for three edges with idle input.
    reset  = 1'b0;
    PortIn = 8'h00;
    drive(A_MEM, 32'h0, 1'b0, 1'b0);
    repeat (3) tick("reset");
    reset = 1'b1;
    drive(A_ST, 32'h0, 1'b0, 1'b1);
    chk("rst_status", bus.ReadData, 32'h0);
    chk("rst_pout", PortOut, 32'h0);
    chk("rst_chg", {31'h0, InChanged}, 32'h0);
    check_all("rst_read");

    // Output register store and read back.
    drive(A_OUT, 32'hDEAD_BEEF, 1'b1, 1'b0);
    tick("store_out");
    chk("pout_store", PortOut, 32'hDEAD_BEEF);
    drive(A_OUT, 32'h0, 1'b0, 1'b1);
    chk("rd_out", bus.ReadData, 32'hDEAD_BEEF);
    chk("iosel_out", {31'h0, bus.IOSelect}, 32'h1);
    drive(A_MEM, 32'h0, 1'b0, 1'b1);
    chk("iosel_mem", {31'h0, bus.IOSelect}, 32'h0);
    chk("rd_mem", bus.ReadData, 32'h0);

    // Input change latency.
    drive(A_MEM, 32'h0, 1'b0, 1'b0);
    PortIn = 8'hA5;
    repeat (LAT) begin
      tick("lat_a5");
      chk("lat_a5_pre", {31'h0, InChanged}, 32'h0);
    end
    tick("lat_a5_acc");
    chk("lat_a5_set", {31'h0, InChanged}, 32'h1);
    drive(A_IN, 32'h0, 1'b0, 1'b1);
    chk("rd_in_a5", bus.ReadData, 32'h0000_00A5);
    drive(A_ST, 32'h0, 1'b0, 1'b1);
    chk("rd_st_a5", bus.ReadData, 32'h1);
    tick("st_clear");
    chk("st_cleared", {31'h0, InChanged}, 32'h0);

    // Short pulse, then return to the accepted value.
    drive(A_MEM, 32'h0, 1'b0, 1'b0);
    PortIn = 8'h01;
    repeat (10) tick("pulse");
    PortIn = 8'hA5;
    repeat (LAT + 4) tick("pulse_end");
    drive(A_ST, 32'h0, 1'b0, 1'b1);
    tick("pulse_clr");

    // Held value accepted after the full latency.
    drive(A_MEM, 32'h0, 1'b0, 1'b0);
    PortIn = 8'h3C;
    repeat (LAT) begin
      tick("hold_3c");
      chk("hold_3c_pre", {31'h0, InChanged}, 32'h0);
    end
    tick("hold_3c_acc");
    drive(A_ST, 32'h0, 1'b0, 1'b1);
    chk("rd_st_3c", bus.ReadData, 32'h1);
    tick("hold_3c_clr");

    // Status read coincident with an accept: set wins; W1C next cycle.
    PortIn = 8'hC3;
    drive(A_ST, 32'h0, 1'b0, 1'b1);
    repeat (LAT + 1) tick("coinc");
    chk("coinc_set", {31'h0, InChanged}, 32'h1);
    drive(A_ST, 32'h1, 1'b1, 1'b0);
    tick("w1c");
    chk("w1c_clear", {31'h0, InChanged}, 32'h0);

    // Reset part-way through an acceptance window.
    drive(A_OUT, 32'h1234_5678, 1'b1, 1'b0);
    tick("pre_rst_store");
    drive(A_MEM, 32'h0, 1'b0, 1'b0);
    PortIn = 8'h5A;
    repeat (10) tick("mid_db");
    reset = 1'b0;
    tick("mid_rst");
    chk("mid_rst_pout", PortOut, 32'h0);
    chk("mid_rst_chg", {31'h0, InChanged}, 32'h0);
    drive(A_IN, 32'h0, 1'b0, 1'b1);
    chk("mid_rst_in", bus.ReadData, 32'h0);
    reset = 1'b1;
    drive(A_MEM, 32'h0, 1'b0, 1'b0);
    repeat (LAT) begin
      tick("reacc");
      chk("reacc_pre", {31'h0, InChanged}, 32'h0);
    end
    tick("reacc_acc");
    chk("reacc_set", {31'h0, InChanged}, 32'h1);
    drive(A_IN, 32'h0, 1'b0, 1'b1);
    chk("reacc_in", bus.ReadData, 32'h0000_005A);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      logic [31:0] a;
      case ($urandom_range(0, 3))
        0:       a = A_OUT;
        1:       a = A_IN;
        2:       a = A_ST;
        default: a = A_MEM + 32'($urandom_range(0, 15) * 4);
      endcase
      a[1:0] = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 11) == 0) PortIn = 8'($urandom());
      reset = ($urandom_range(0, 99) != 0);
      drive(a, $urandom(), ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
      check_all("rnd_comb");
      tick("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
